// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
//   Bundles the byte-stream handshake feeding the program loader and the
//   instruction-memory write port the loader drives.
//
//   Stream  : in_valid, in_data (source -> loader), in_ready (loader -> source)
//   Memory  : prog_addr, prog_data, prog_we, prog_enable (loader -> memory)
//
//   Modports
//     master : the environment side (stream source + instruction memory)
//     slave  : the loader side
// ---------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_we;
  logic                  prog_enable;

  modport master (
    output in_valid, in_data,
    input  in_ready, prog_addr, prog_data, prog_we, prog_enable
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, prog_addr, prog_data, prog_we, prog_enable
  );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Loads a program into the instruction memory from a byte stream
//   (header, one byte per instruction word, optional checksum byte) while
//   holding the CPU in reset, then releases the CPU RELEASE_DELAY cycles
//   after giving the memory address mux back.
//
//   Header byte: low ADDR_WIDTH bits = index of the last word (words = last+1);
//   any set bit above that is a malformed header and ends in ERROR.
//   Requires DATA_WIDTH > ADDR_WIDTH.
//
//   Ports
//     prog_clk    : single clock; memory writes on rising edge with prog_we=1
//     prog_reset  : asynchronous, active-high reset
//     load_req    : one-cycle pulse, starts a load from IDLE, RUN or ERROR
//     bus         : prog_loader_if.slave (stream in, memory write port out)
//     cpu_reset   : active-high CPU reset, low only in RUN
//     done        : high in RUN
//     error       : high in ERROR
//
//   Optional feature (macro PROG_LOADER_CHECKSUM_EN): after the last write
//   one checksum byte is accepted; the load succeeds only if header + data +
//   checksum sums to zero modulo 2**DATA_WIDTH.
//
//   All outputs are registered; they are computed from the next state.
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int RELEASE_DELAY = 2
) (
  input  logic           prog_clk,
  input  logic           prog_reset,
  input  logic           load_req,
  prog_loader_if.slave   bus,
  output logic           cpu_reset,
  output logic           done,
  output logic           error
);

  localparam int CNT_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] last, last_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] prog_addr_d;
  logic [DATA_WIDTH-1:0] prog_data_d;
  logic                  in_ready_d, prog_we_d, prog_enable_d;
  logic                  cpu_reset_d, done_d, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum, sum_d;
`endif

  // in_ready is registered from the state, so a transfer is just this AND.
  logic xfer;
  logic hdr_bad;
  assign xfer    = bus.in_valid && bus.in_ready;
  assign hdr_bad = (bus.in_data[DATA_WIDTH-1:ADDR_WIDTH] != '0);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state           <= S_IDLE;
      last            <= '0;
      cnt             <= '0;
      bus.prog_addr   <= '0;
      bus.prog_data   <= '0;
      bus.prog_we     <= 1'b0;
      bus.prog_enable <= 1'b0;
      bus.in_ready    <= 1'b0;
      cpu_reset       <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum             <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_d;
      last            <= last_d;
      cnt             <= cnt_d;
      bus.prog_addr   <= prog_addr_d;
      bus.prog_data   <= prog_data_d;
      bus.prog_we     <= prog_we_d;
      bus.prog_enable <= prog_enable_d;
      bus.in_ready    <= in_ready_d;
      cpu_reset       <= cpu_reset_d;
      done            <= done_d;
      error           <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum             <= sum_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state;
    unique case (state)
      S_IDLE:   if (load_req) state_d = S_HEADER;
      S_HEADER: if (xfer)     state_d = hdr_bad ? S_ERROR : S_DATA;
      S_DATA:   if (xfer)     state_d = S_WRITE;
      S_WRITE: begin
        // Stopping at 'last' (<= max address) means the address never wraps.
        if (bus.prog_addr == last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_RELEASE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: if (xfer) state_d = (DATA_WIDTH'(sum + bus.in_data) == '0) ? S_RELEASE : S_ERROR;
`endif
      S_RELEASE: if (cnt == CNT_W'(RELEASE_DELAY - 1)) state_d = S_RUN;
      S_RUN:     if (load_req) state_d = S_HEADER;
      S_ERROR:   if (load_req) state_d = S_HEADER;
      default:   state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    last_d      = last;
    cnt_d       = cnt;
    prog_addr_d = bus.prog_addr;
    prog_data_d = bus.prog_data;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum;
`endif

    // Strobes and status follow the state being entered.
    in_ready_d    = (state_d == S_HEADER) || (state_d == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                    || (state_d == S_CHECK)
`endif
                    ;
    prog_we_d     = (state_d == S_WRITE);
    prog_enable_d = in_ready_d || (state_d == S_WRITE);
    cpu_reset_d   = (state_d != S_RUN);
    done_d        = (state_d == S_RUN);
    error_d       = (state_d == S_ERROR);

    // Fresh load: restart the address and the running sum.
    if (state_d == S_HEADER && state != S_HEADER) begin
      prog_addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d       = '0;
`endif
    end

    if (state == S_HEADER && xfer) begin
      last_d = bus.in_data[ADDR_WIDTH-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d  = sum + bus.in_data;
`endif
    end

    if (state == S_DATA && xfer) begin
      prog_data_d = bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d       = sum + bus.in_data;
`endif
    end

    if (state == S_WRITE && state_d == S_DATA)
      prog_addr_d = bus.prog_addr + ADDR_WIDTH'(1);

    // Hand the memory port back clean and start the release countdown.
    if (state_d == S_RELEASE && state != S_RELEASE) begin
      prog_addr_d = '0;
      prog_data_d = '0;
      cnt_d       = '0;
    end else if (state == S_RELEASE) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader. Stimulus tasks push the expected memory
//   writes into a queue; a monitor on the falling edge pops and compares
//   every prog_we strobe. Status outputs are compared inline.
//   Builds with or without PROG_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_prog_loader;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RD = 2;

  logic prog_clk   = 1'b0;
  logic prog_reset = 1'b1;
  logic load_req   = 1'b0;
  logic cpu_reset, done, error;

  prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RELEASE_DELAY(RD)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load_req   (load_req),
    .bus        (bus.slave),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge prog_clk) begin
    if (!prog_reset && bus.prog_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write",
                 bus.prog_addr, bus.prog_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_addr", bus.prog_addr, exp_w.addr);
        check("write_data", bus.prog_data, exp_w.data);
        check("write_enable", bus.prog_enable, 1);
      end
    end
  end

  // Caller is at a falling edge; load_req is high across exactly one rising edge.
  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge prog_clk);
    load_req = 1'b0;
  endtask

  // Idle 'gap' cycles (optionally pulsing load_req in the first), then offer
  // the byte until taken. Returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit lr);
    int budget;
    for (int i = 0; i < gap; i++) begin
      load_req = lr && (i == 0);
      @(negedge prog_clk);
      load_req = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (!bus.in_ready && budget < 100) begin
      @(negedge prog_clk);
      budget++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(negedge prog_clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Full load: optional load_req, header, data bytes (expected writes queued),
  // and the checksum byte when the feature is built in.
  task automatic run_load(input bit do_req, input logic [7:0] hdr,
                          input logic [7:0] bytes[$], input bit gaps);
    logic [7:0] s;
    s = hdr;
    if (do_req) begin
      pulse_load();
      check("load_cpu_reset", cpu_reset, 1);
      check("load_done_clear", done, 0);
    end
    send_byte(hdr, 0, 1'b0);
    foreach (bytes[i]) begin
      exp_q.push_back(wr_t'{AW'(i), bytes[i]});
      s = s + bytes[i];
      send_byte(bytes[i], gaps ? ((i % 3) + (i % 2)) : 0, gaps);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(~s + 8'd1, gaps ? 2 : 0, gaps);
`endif
  endtask

  // prog_enable must fall first, then cpu_reset exactly RD cycles later.
  task automatic check_release(input string tag);
    int n;
    n = 0;
    while (bus.prog_enable && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    check({tag, "_enable_fall"}, bus.prog_enable, 0);
    check({tag, "_cpu_held"}, cpu_reset, 1);
    check({tag, "_ready_low"}, bus.in_ready, 0);
    n = 0;
    while (cpu_reset && n < 20) begin
      @(negedge prog_clk);
      n++;
    end
    check({tag, "_release_delay"}, n, RD);
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_addr_zero"}, bus.prog_addr, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    logic [7:0] bq[$];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (2) @(negedge prog_clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_enable", bus.prog_enable, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_we", bus.prog_we, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    prog_reset = 1'b0;
    @(negedge prog_clk);

    // load_req together with in_valid in IDLE: byte must not be consumed
    load_req     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    check("idle_ready_low", bus.in_ready, 0);
    @(negedge prog_clk);
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    check("header_ready", bus.in_ready, 1);
    check("header_enable", bus.prog_enable, 1);
    bq = '{8'h77};
    run_load(1'b0, 8'h00, bq, 1'b0);
    check_release("same_cycle");

    // Two-word program
    bq = '{8'hA3, 8'h5C};
    run_load(1'b1, 8'h01, bq, 1'b0);
    check_release("two_words");

    // Full 16-word program, no 17th write
    w0 = n_writes;
    bq = {};
    for (int i = 0; i < 16; i++) bq.push_back(8'(i));
    run_load(1'b1, 8'h0F, bq, 1'b0);
    check_release("full");
    repeat (3) @(negedge prog_clk);
    check("full_write_count", n_writes - w0, 16);

    // Malformed header
    w0 = n_writes;
    pulse_load();
    send_byte(8'h20, 0, 1'b0);
    check("bad_hdr_error", error, 1);
    check("bad_hdr_cpu_reset", cpu_reset, 1);
    check("bad_hdr_enable", bus.prog_enable, 0);
    check("bad_hdr_ready", bus.in_ready, 0);
    repeat (3) @(negedge prog_clk);
    check("bad_hdr_error_hold", error, 1);
    check("bad_hdr_no_writes", n_writes - w0, 0);
    pulse_load();
    check("err_reload_error", error, 0);
    check("err_reload_ready", bus.in_ready, 1);
    bq = '{8'h11};
    run_load(1'b0, 8'h00, bq, 1'b0);
    check_release("after_error");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Wrong checksum, then the correct one
    exp_q.push_back(wr_t'{4'd0, 8'hA3});
    exp_q.push_back(wr_t'{4'd1, 8'h5C});
    pulse_load();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hA3, 0, 1'b0);
    send_byte(8'h5C, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    check("cks_bad_error", error, 1);
    check("cks_bad_cpu_reset", cpu_reset, 1);
    check("cks_bad_done", done, 0);
    exp_q.push_back(wr_t'{4'd0, 8'hA3});
    exp_q.push_back(wr_t'{4'd1, 8'h5C});
    pulse_load();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hA3, 0, 1'b0);
    send_byte(8'h5C, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check_release("cks_good");
`endif

    // Gaps in in_valid with ignored load_req pulses
    w0 = n_writes;
    bq = '{8'h10, 8'hFF, 8'h00, 8'h81, 8'h3C, 8'hE7};
    run_load(1'b1, 8'h05, bq, 1'b1);
    check_release("gaps");
    check("gaps_write_count", n_writes - w0, 6);

    // Asynchronous reset in the middle of a load
    exp_q.push_back(wr_t'{4'd0, 8'h5A});
    exp_q.push_back(wr_t'{4'd1, 8'hC3});
    pulse_load();
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'hC3, 0, 1'b0);
    @(negedge prog_clk);
    check("pre_rst_enable", bus.prog_enable, 1);
    #2 prog_reset = 1'b1;
    #1;
    check("async_rst_cpu_reset", cpu_reset, 1);
    check("async_rst_enable", bus.prog_enable, 0);
    check("async_rst_ready", bus.in_ready, 0);
    check("async_rst_done", done, 0);
    check("async_rst_error", error, 0);
    check("async_rst_addr", bus.prog_addr, 0);
    check("async_rst_queue", exp_q.size(), 0);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    repeat (2) @(negedge prog_clk);
    check("post_rst_idle_ready", bus.in_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
